// File: rtl/cluster_clk_pkg.sv
// Shared types for the cluster clock gate controller.
package cluster_clk_pkg;

    typedef enum logic [2:0] {
        CG_ON    = 3'd0,
        CG_DRAIN = 3'd1,
        CG_OFF   = 3'd2,
        CG_WAKE  = 3'd3
    } clk_gate_state_e;

endpackage

// File: rtl/cluster_clock_gate_ctrl.sv
// Decides when the cluster clock may stop: idle detection, req/ack quiesce,
// and a settle window on wake-up before reporting the clock as running.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// CG_ON    | clock running and settled, counting consecutive idle cycles
// CG_DRAIN | clock on, quiesce requested, waiting for ack or new activity
// CG_OFF   | clock gated, waiting for activity or a wake request
// CG_WAKE  | clock re-enabled, settle window before clk_on_o asserts
module cluster_clock_gate_ctrl
    import cluster_clk_pkg::*;
#(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  test_en_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    output logic                  quiesce_req_o,
    input  logic                  quiesce_ack_i,
    output logic                  clk_en_o,
    output logic                  clk_on_o,
    output logic [2:0]            state_o
);

    localparam int WAKE_CNT_W = 8;
    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX  = '1;

    clk_gate_state_e       state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic                  clk_en_q, clk_on_q, quiesce_q;
    logic                  idle;
    logic                  thresh_hit;

    assign idle = !busy_i && !wake_req_i;
    // Equality compare: lowering the threshold below the running count
    // postpones gating until the count restarts.
    assign thresh_hit = (idle_thresh_i != '0) &&
                        (idle_cnt_q == (idle_thresh_i - IDLE_CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            CG_ON: begin
                if (idle) begin
                    if (thresh_hit) begin
                        state_d = CG_DRAIN;
                    end else if (idle_cnt_q != IDLE_MAX) begin
                        idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
                    end else begin
                        idle_cnt_d = idle_cnt_q;
                    end
                end
            end
            CG_DRAIN: begin
                // New activity wins over a simultaneous ack.
                if (!idle) begin
                    state_d = CG_ON;
                end else if (quiesce_ack_i) begin
                    state_d = CG_OFF;
                end
            end
            CG_OFF: begin
                if (!idle) begin
                    state_d = CG_WAKE;
                end
            end
            CG_WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = CG_ON;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
                end
            end
            default: state_d = CG_ON;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= CG_ON;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_q   <= 1'b1;
            clk_on_q   <= 1'b1;
            quiesce_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            clk_en_q   <= (state_d != CG_OFF);
            clk_on_q   <= (state_d == CG_ON);
            quiesce_q  <= (state_d == CG_DRAIN);
        end
    end

    always_comb begin
        case (state_q)
            CG_ON, CG_DRAIN, CG_OFF, CG_WAKE: state_o = state_q;
            default:                          state_o = CG_ON;
        endcase
    end

    // The only combinational output: DFT override straight into the gate enable.
    assign clk_en_o      = clk_en_q | test_en_i;
    assign clk_on_o      = clk_on_q;
    assign quiesce_req_o = quiesce_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Bench for cluster_clock_gate_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the gating rules.
module tb_cluster_clock_gate_ctrl;

    localparam int IDLE_CNT_W  = 8;
    localparam int WAKE_CYCLES = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  test_en_i;
    logic [IDLE_CNT_W-1:0] idle_thresh_i;
    logic                  busy_i;
    logic                  wake_req_i;
    logic                  quiesce_req_o;
    logic                  quiesce_ack_i;
    logic                  clk_en_o;
    logic                  clk_on_o;
    logic [2:0]            state_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0=on 1=drain 2=off 3=wake
    int m_mode       = 0;
    int m_idle_run   = 0;
    int m_wake_left  = 0;

    cluster_clock_gate_ctrl #(
        .IDLE_CNT_W  (IDLE_CNT_W),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .test_en_i     (test_en_i),
        .idle_thresh_i (idle_thresh_i),
        .busy_i        (busy_i),
        .wake_req_i    (wake_req_i),
        .quiesce_req_o (quiesce_req_o),
        .quiesce_ack_i (quiesce_ack_i),
        .clk_en_o      (clk_en_o),
        .clk_on_o      (clk_on_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Consecutive idle cycles reaching the threshold starts the drain.
    task automatic model_update();
        bit idle;
        idle = !busy_i && !wake_req_i;
        if (!rst_ni) begin
            m_mode = 0; m_idle_run = 0; m_wake_left = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (!idle) m_idle_run = 0;
                else if (idle_thresh_i != 0 && m_idle_run + 1 == int'(idle_thresh_i)) begin
                    m_mode = 1; m_idle_run = 0;
                end else if (m_idle_run < 255) m_idle_run++;
            end
            1: begin
                if (!idle) m_mode = 0;
                else if (quiesce_ack_i) m_mode = 2;
            end
            2: begin
                if (!idle) begin m_mode = 3; m_wake_left = WAKE_CYCLES; end
            end
            default: begin
                m_wake_left--;
                if (m_wake_left == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        chk_eq("state",   int'(state_o),       m_mode);
        chk_eq("clk_on",  int'(clk_on_o),      int'(m_mode == 0));
        chk_eq("quiesce", int'(quiesce_req_o), int'(m_mode == 1));
        chk_eq("clk_en",  int'(clk_en_o),      int'(m_mode != 2 || test_en_i));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        rst_ni = 1'b0; test_en_i = 1'b0; idle_thresh_i = 8'd4;
        busy_i = 1'b0; wake_req_i = 1'b0; quiesce_ack_i = 1'b0;

        // 1: reset state, then gating after exactly 4 idle cycles
        step();
        chk_eq("rst_state", int'(state_o), 0);
        chk_eq("rst_clk_en", int'(clk_en_o), 1);
        chk_eq("rst_clk_on", int'(clk_on_o), 1);
        chk_eq("rst_quiesce", int'(quiesce_req_o), 0);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("t1_still_on", int'(state_o), 0);
        end
        step();
        chk_eq("t1_drain", int'(state_o), 1);
        chk_eq("t1_quiesce", int'(quiesce_req_o), 1);

        // 2: ack gates the clock
        quiesce_ack_i = 1'b1;
        step();
        quiesce_ack_i = 1'b0;
        chk_eq("t2_off", int'(state_o), 2);
        chk_eq("t2_clk_en", int'(clk_en_o), 0);
        chk_eq("t2_clk_on", int'(clk_on_o), 0);
        chk_eq("t2_quiesce", int'(quiesce_req_o), 0);

        // 3: one-cycle wake pulse, busy toggling inside the settle window
        wake_req_i = 1'b1;
        step();
        wake_req_i = 1'b0;
        chk_eq("t3_clk_en", int'(clk_en_o), 1);
        chk_eq("t3_wake", int'(state_o), 3);
        for (int i = 0; i < WAKE_CYCLES - 1; i++) begin
            busy_i = ~busy_i;
            step();
            chk_eq("t3_not_settled", int'(clk_on_o), 0);
        end
        busy_i = 1'b0;
        step();
        chk_eq("t3_clk_on", int'(clk_on_o), 1);
        chk_eq("t3_on", int'(state_o), 0);

        // 4: busy with simultaneous ack aborts the drain and restarts counting
        for (int i = 0; i < 4; i++) step();
        chk_eq("t4_drain", int'(state_o), 1);
        busy_i = 1'b1; quiesce_ack_i = 1'b1;
        step();
        busy_i = 1'b0; quiesce_ack_i = 1'b0;
        chk_eq("t4_abort", int'(state_o), 0);
        chk_eq("t4_quiesce", int'(quiesce_req_o), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("t4_restart", int'(state_o), 0);
        end
        step();
        chk_eq("t4_drain_again", int'(state_o), 1);

        // 5: test override while gated
        quiesce_ack_i = 1'b1;
        step();
        quiesce_ack_i = 1'b0;
        chk_eq("t5_off", int'(state_o), 2);
        test_en_i = 1'b1;
        #1;
        chk_eq("t5_clk_en_comb", int'(clk_en_o), 1);
        step();
        chk_eq("t5_state", int'(state_o), 2);
        chk_eq("t5_clk_on", int'(clk_on_o), 0);
        test_en_i = 1'b0;
        #1;
        chk_eq("t5_clk_en_release", int'(clk_en_o), 0);

        // 6: reset while gated, then auto-gating disabled
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk_eq("t6_rst_state", int'(state_o), 0);
        chk_eq("t6_rst_clk_en", int'(clk_en_o), 1);
        idle_thresh_i = 8'd0;
        for (int i = 0; i < 1000; i++) step();
        chk_eq("t6_thresh0_on", int'(state_o), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) idle_thresh_i = 8'($urandom_range(7));
            busy_i        = ($urandom_range(9) == 0);
            wake_req_i    = ($urandom_range(19) == 0);
            quiesce_ack_i = $urandom_range(1) == 1;
            test_en_i     = ($urandom_range(15) == 0);
            rst_ni        = ($urandom_range(299) != 0);
            #1;
            chk_eq("rnd_clk_en_comb", int'(clk_en_o), int'(m_mode != 2 || test_en_i));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
